// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the multicycle RISC datapath stages.
package cpu_isa_pkg;

  // Datapath width shared by the execute, access and writeback stages
  localparam int unsigned DW = 8;

  // Instruction field positions
  localparam int unsigned IRW     = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 11;
  localparam int unsigned RD_MSB  = 10;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned OPW     = OPC_MSB - OPC_LSB + 1;
  localparam int unsigned RDW     = RD_MSB - RD_LSB + 1;

  // Opcodes
  localparam logic [OPW-1:0] OP_NOP = 5'b00000;
  localparam logic [OPW-1:0] OP_ADD = 5'b00001;
  localparam logic [OPW-1:0] OP_SUB = 5'b00010;
  localparam logic [OPW-1:0] OP_AND = 5'b00011;
  localparam logic [OPW-1:0] OP_STA = 5'b00100;
  localparam logic [OPW-1:0] OP_LDA = 5'b00101;
  localparam logic [OPW-1:0] OP_OR  = 5'b00110;
  localparam logic [OPW-1:0] OP_XOR = 5'b00111;
  localparam logic [OPW-1:0] OP_IN  = 5'b01000;
  localparam logic [OPW-1:0] OP_OUT = 5'b01001;
  localparam logic [OPW-1:0] OP_MOV = 5'b01010;

  // Writeback behaviour classes
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,  // no register write, flags kept
    WB_ALU  = 2'd1,  // write ALUOUT, update flags
    WB_MOV  = 2'd2,  // write ALUOUT, flags kept
    WB_LOAD = 2'd3   // write Rtemp, flags kept
  } wb_class_e;

  // Register-file write request
  typedef struct packed {
    logic           en;
    logic [RDW-1:0] addr;
    logic [DW-1:0]  data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_2r1w.sv
// General register file: two asynchronous read ports, one synchronous write port.
module regfile_2r1w #(
  parameter int unsigned NREG = 8,
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_sel,
  input  logic [AW-1:0] rb_sel,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data
);

  logic [DW-1:0] regs [NREG];

  // Write port with asynchronous clear of every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: no bypass, a same-cycle write is seen after the edge
  assign ra_data = regs[ra_sel];
  assign rb_data = regs[rb_sel];

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: commits results on the T3 rising edge, updates flags and counts retirements.
module writeback_stage #(
  parameter int unsigned DW   = cpu_isa_pkg::DW,
  parameter int unsigned NREG = 8,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            T3,
  input  logic [15:0]     IR,
  input  logic [DW-1:0]   ALUOUT,
  input  logic [DW-1:0]   Rtemp,
  input  logic            alu_z,
  input  logic            alu_c,
  input  logic [2:0]      ra_sel,
  input  logic [2:0]      rb_sel,
  output logic [DW-1:0]   ra_data,
  output logic [DW-1:0]   rb_data,
  output logic            flag_z,
  output logic            flag_c,
  output logic            wb_done,
  output logic [CNTW-1:0] retired
);

  import cpu_isa_pkg::*;

  localparam int unsigned AW = 3;

  logic            t3_q;
  logic            commit_c;
  logic [OPW-1:0]  opc_c;
  logic [AW-1:0]   rd_c;
  wb_class_e       cls_c;
  logic            we_c;
  logic [DW-1:0]   wdata_c;
  logic            unused_ir;

  assign opc_c     = IR[OPC_MSB:OPC_LSB];
  assign rd_c      = IR[RD_MSB:RD_LSB];
  assign unused_ir = ^IR[RD_LSB-1:0];

  // Single commit per T3 assertion, however long the strobe is held
  assign commit_c = T3 & ~t3_q;

  // Opcode-class decode
  always_comb begin
    cls_c = WB_NONE;
    unique case (opc_c)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: cls_c = WB_ALU;
      OP_MOV:                                cls_c = WB_MOV;
      OP_LDA, OP_IN:                         cls_c = WB_LOAD;
      OP_STA, OP_OUT, OP_NOP:                cls_c = WB_NONE;
      default:                               cls_c = WB_NONE;
    endcase
  end

  // Register write request for this commit
  always_comb begin
    we_c    = 1'b0;
    wdata_c = ALUOUT;
    if (commit_c && (cls_c != WB_NONE)) begin
      we_c = 1'b1;
    end
    if (cls_c == WB_LOAD) begin
      wdata_c = Rtemp;
    end
  end

  regfile_2r1w #(
    .NREG (NREG),
    .DW   (DW),
    .AW   (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we_c),
    .waddr   (rd_c),
    .wdata   (wdata_c),
    .ra_sel  (ra_sel),
    .rb_sel  (rb_sel),
    .ra_data (ra_data),
    .rb_data (rb_data)
  );

  // Strobe edge detect, done pulse, retirement counter and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t3_q    <= 1'b0;
      wb_done <= 1'b0;
      retired <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      t3_q    <= T3;
      wb_done <= commit_c;
      if (commit_c) begin
        retired <= retired + CNTW'(1);
        if (cls_c == WB_ALU) begin
          flag_z <= alu_z;
          flag_c <= alu_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard testbench for writeback_stage.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        T3;
  logic [15:0] IR;
  logic [7:0]  ALUOUT;
  logic [7:0]  Rtemp;
  logic        alu_z;
  logic        alu_c;
  logic [2:0]  ra_sel;
  logic [2:0]  rb_sel;
  logic [7:0]  ra_data;
  logic [7:0]  rb_data;
  logic        flag_z;
  logic        flag_c;
  logic        wb_done;
  logic [15:0] retired;

  // Narrow-counter instance used to exercise counter wrap-around quickly
  logic [7:0]  ra_data_s;
  logic [7:0]  rb_data_s;
  logic        flag_z_s;
  logic        flag_c_s;
  logic        wb_done_s;
  logic [3:0]  retired_s;

  writeback_stage #(.DW(8), .NREG(8), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .T3(T3), .IR(IR), .ALUOUT(ALUOUT), .Rtemp(Rtemp),
    .alu_z(alu_z), .alu_c(alu_c), .ra_sel(ra_sel), .rb_sel(rb_sel),
    .ra_data(ra_data), .rb_data(rb_data), .flag_z(flag_z), .flag_c(flag_c),
    .wb_done(wb_done), .retired(retired)
  );

  writeback_stage #(.DW(8), .NREG(8), .CNTW(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .T3(T3), .IR(IR), .ALUOUT(ALUOUT), .Rtemp(Rtemp),
    .alu_z(alu_z), .alu_c(alu_c), .ra_sel(ra_sel), .rb_sel(rb_sel),
    .ra_data(ra_data_s), .rb_data(rb_data_s), .flag_z(flag_z_s), .flag_c(flag_c_s),
    .wb_done(wb_done_s), .retired(retired_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ret;
    logic        z;
    logic        c;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  m_regs [8];
  logic        m_z;
  logic        m_c;
  logic [15:0] m_ret;

  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_z   = 1'b0;
    m_c   = 1'b0;
    m_ret = 16'h0000;
  endtask

  // Reference behaviour of one commit; pushes the expected post-commit state
  task automatic model_commit(input logic [15:0] ir, input logic [7:0] alu,
                              input logic [7:0] rt, input logic z, input logic c);
    logic [4:0] opc;
    logic [2:0] rd;
    exp_t       e;
    opc = ir[15:11];
    rd  = ir[10:8];
    case (opc)
      5'b00001, 5'b00010, 5'b00011, 5'b00110, 5'b00111: begin
        m_regs[rd] = alu;
        m_z = z;
        m_c = c;
      end
      5'b01010:           m_regs[rd] = alu;
      5'b00101, 5'b01000: m_regs[rd] = rt;
      default: ;
    endcase
    m_ret = m_ret + 16'd1;
    e.ret = m_ret;
    e.z   = m_z;
    e.c   = m_c;
    sb.push_back(e);
  endtask

  task automatic do_commit(input logic [15:0] ir, input logic [7:0] alu,
                           input logic [7:0] rt, input logic z, input logic c);
    model_commit(ir, alu, rt, z, c);
    IR = ir; ALUOUT = alu; Rtemp = rt; alu_z = z; alu_c = c; T3 = 1'b1;
    @(negedge clk);
    T3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reg(input string tag, input logic [2:0] sel);
    ra_sel = sel;
    rb_sel = sel;
    #1;
    check({tag, "_ra"}, 32'(ra_data), 32'(m_regs[sel]));
    check({tag, "_rb"}, 32'(rb_data), 32'(m_regs[sel]));
  endtask

  // Scoreboard: each wb_done pulse must match the oldest pending commit
  always @(negedge clk) begin
    if (rst_n && wb_done) begin
      if (sb.size() == 0) begin
        check("wb_done_spurious", 32'(wb_done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("retired", 32'(retired), 32'(e.ret));
        check("retired_narrow", 32'(retired_s), 32'(e.ret[3:0]));
        check("flag_z", 32'(flag_z), 32'(e.z));
        check("flag_c", 32'(flag_c), 32'(e.c));
        check("wb_done_narrow", 32'(wb_done_s), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [4:0] ops [12];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ops[0] = 5'b00001; ops[1] = 5'b00010; ops[2]  = 5'b00011; ops[3]  = 5'b00110;
    ops[4] = 5'b00111; ops[5] = 5'b01010; ops[6]  = 5'b00101; ops[7]  = 5'b01000;
    ops[8] = 5'b00100; ops[9] = 5'b01001; ops[10] = 5'b00000; ops[11] = 5'b11111;
    rst_n = 1'b0; T3 = 1'b0; IR = 16'h0000; ALUOUT = 8'h00; Rtemp = 8'h00;
    alu_z = 1'b0; alu_c = 1'b0; ra_sel = 3'd0; rb_sel = 3'd0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) check_reg("reset_reg", 3'(i));
    check("reset_flag_z", 32'(flag_z), 32'd0);
    check("reset_flag_c", 32'(flag_c), 32'd0);
    check("reset_wb_done", 32'(wb_done), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU, load, IN and store commits
    do_commit(16'h0B00, 8'h5A, 8'h00, 1'b0, 1'b1);
    check_reg("add_r3", 3'd3);
    check("add_r3_value", 32'(ra_data), 32'h5A);
    do_commit(16'h2D00, 8'h11, 8'hC3, 1'b1, 1'b0);
    check_reg("lda_r5", 3'd5);
    check("lda_r5_value", 32'(ra_data), 32'hC3);
    do_commit(16'h4500, 8'h22, 8'h3C, 1'b1, 1'b0);
    check_reg("in_r5", 3'd5);
    do_commit(16'h2300, 8'hFF, 8'hEE, 1'b1, 1'b1);
    check_reg("sta_r3", 3'd3);
    check("sta_r3_value", 32'(ra_data), 32'h5A);

    // Held strobe: one commit; old value during the commit cycle, new value after
    ra_sel = 3'd3;
    model_commit(16'h0B00, 8'h77, 8'h00, 1'b1, 1'b0);
    IR = 16'h0B00; ALUOUT = 8'h77; Rtemp = 8'h00; alu_z = 1'b1; alu_c = 1'b0; T3 = 1'b1;
    #1;
    check("read_commit_cycle", 32'(ra_data), 32'h5A);
    @(negedge clk);
    check("read_after_commit", 32'(ra_data), 32'h77);
    repeat (3) @(negedge clk);
    T3 = 1'b0;
    @(negedge clk);
    check("held_retired", 32'(retired), 32'd5);

    // Mixed opcodes across random registers, including undefined codes
    for (int k = 0; k < 12; k++) begin
      logic [2:0] rd;
      rd = 3'($urandom_range(0, 7));
      do_commit({ops[k], rd, 8'h00}, 8'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom));
      check_reg("mixed", rd);
      check_reg("mixed_other", 3'($urandom_range(0, 7)));
    end
    check("wrap_narrow", 32'(retired_s), 32'd1);
    check("count_wide", 32'(retired), 32'd17);

    // Reset in the commit cycle abandons the write and clears everything
    IR = 16'h0E00; ALUOUT = 8'h99; Rtemp = 8'h00; alu_z = 1'b1; alu_c = 1'b1; T3 = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_reg("rst_mid_r6", 3'd6);
    check_reg("rst_mid_r3", 3'd3);
    check("rst_mid_retired", 32'(retired), 32'd0);
    check("rst_mid_flag_z", 32'(flag_z), 32'd0);
    check("rst_mid_flag_c", 32'(flag_c), 32'd0);
    check("rst_mid_wb_done", 32'(wb_done), 32'd0);

    // Release with T3 still high: the instruction restarts on the first edge
    rst_n = 1'b1;
    model_commit(16'h0E00, 8'h99, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    T3 = 1'b0;
    check_reg("restart_r6", 3'd6);
    repeat (3) @(negedge clk);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
